// File: rtl/layer_seq_pkg.sv
// rtl/layer_seq_pkg.sv - shared types for the descriptor-driven layer sequencer
package layer_seq_pkg;

  localparam int DESC_AW = 32;
  localparam int DESC_DW = 8;

  typedef enum logic [1:0] {
    CONV = 2'd0,
    POOL = 2'd1,
    FC   = 2'd2
  } layer_type_e;

  typedef struct packed {
    layer_type_e        layer_type;
    logic               stride;
    logic [1:0]         window_dim;
    logic [DESC_DW-1:0] input_dim;
    logic [DESC_AW-1:0] w_base;
    logic [DESC_AW-1:0] b_base;
    logic [DESC_AW-1:0] d_read_base;
    logic [DESC_AW-1:0] d_write_base;
    logic [DESC_AW-1:0] operand_words;
  } layer_desc_t;

  localparam int DESC_WIDTH = $bits(layer_desc_t);

  typedef enum logic [2:0] {
    IDLE, NET_RST, LOAD_W, LOAD_B, STREAM, WAIT_DONE, NEXT, DONE
  } seq_state_e;

endpackage

// File: rtl/layer_descriptor_table.sv
// rtl/layer_descriptor_table.sv - per-layer descriptor register file, sync write, async read
module layer_descriptor_table
  import layer_seq_pkg::*;
#(
  parameter int MAX_LAYERS = 32
) (
  input  logic                          clock,
  input  logic                          wr_en,
  input  logic [$clog2(MAX_LAYERS)-1:0] wr_index,
  input  layer_desc_t                   wr_desc,
  input  logic [$clog2(MAX_LAYERS)-1:0] rd_index,
  output layer_desc_t                   rd_desc
);

  // Contents are left unreset; software must program a slot before it is run.
  layer_desc_t table_q [MAX_LAYERS];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      table_q[wr_index] <= wr_desc;
    end
  end

  assign rd_desc = table_q[rd_index];

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - steps through programmed layers: weight/bias fetch, operand stream, write-back
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int MAX_LAYERS   = 32,
  parameter int WEIGHT_WORDS = 9,
  parameter int BIAS_WORDS   = 9,
  parameter int WORD_BYTES   = 4,
  parameter int DIM_WIDTH    = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          Cfg_WE,
  input  logic [$clog2(MAX_LAYERS)-1:0] Cfg_Index,
  input  logic [DESC_WIDTH-1:0]         Cfg_Descriptor,
  input  logic [$clog2(MAX_LAYERS):0]   Num_Layers,
  input  logic                          Begin_Calc,
  input  logic                          Abort,
  input  logic                          DDR3_Input_Valid,
  output logic                          DDR3_Read_Req,
  output logic [ADDR_WIDTH-1:0]         DDR3_Address,
  output logic                          DDR3_WE,
  output logic [ADDR_WIDTH-1:0]         DDR3_Write_Address,
  input  logic                          Net_Input_Enable,
  input  logic                          Net_Done,
  input  logic                          Net_Result_Valid,
  output logic                          Network_Reset,
  output logic                          Load_Weights,
  output logic                          Load_Biases,
  output logic                          Load_Operands,
  output logic [1:0]                    Layer_Type,
  output logic                          CNN_Stride,
  output logic [1:0]                    CNN_Window_Dim,
  output logic [DIM_WIDTH-1:0]          CNN_Input_Dim,
  output logic [$clog2(MAX_LAYERS)-1:0] Layer_Index,
  output logic                          Busy,
  output logic                          Proc_Done,
  output logic                          Aborted
);

  localparam int IDX_W = $clog2(MAX_LAYERS);
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] layer_q;
  logic [IDX_W:0]   num_q;
  addr_t            cnt_q, wcnt_q;
  layer_desc_t      cur_q, table_desc;
  logic             busy, abort_hit, cnt_inc, cnt_clr, stream_done;
  addr_t            rd_off;

  layer_descriptor_table #(
    .MAX_LAYERS(MAX_LAYERS)
  ) u_table (
    .clock    (clock),
    .wr_en    (Cfg_WE && (state_q == IDLE)),
    .wr_index (Cfg_Index),
    .wr_desc  (layer_desc_t'(Cfg_Descriptor)),
    .rd_index (layer_q),
    .rd_desc  (table_desc)
  );

  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign abort_hit   = busy && Abort;
  assign rd_off      = cnt_q * addr_t'(WORD_BYTES);
  assign stream_done = (cnt_q == addr_t'(cur_q.operand_words));

  always_comb begin
    state_d       = state_q;
    DDR3_Read_Req = 1'b0;
    DDR3_Address  = '0;
    Load_Weights  = 1'b0;
    Load_Biases   = 1'b0;
    Load_Operands = 1'b0;
    cnt_inc       = 1'b0;
    cnt_clr       = 1'b0;
    case (state_q)
      IDLE: begin
        if (Begin_Calc) begin
          state_d = (Num_Layers != '0) ? NET_RST : DONE;
        end
      end
      NET_RST: begin
        state_d = (table_desc.layer_type == POOL) ? STREAM : LOAD_W;
      end
      LOAD_W: begin
        DDR3_Read_Req = 1'b1;
        DDR3_Address  = addr_t'(cur_q.w_base) + rd_off;
        if (DDR3_Input_Valid) begin
          Load_Weights = 1'b1;
          if (cnt_q == addr_t'(WEIGHT_WORDS - 1)) begin
            cnt_clr = 1'b1;
            state_d = LOAD_B;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      LOAD_B: begin
        DDR3_Read_Req = 1'b1;
        DDR3_Address  = addr_t'(cur_q.b_base) + rd_off;
        if (DDR3_Input_Valid) begin
          Load_Biases = 1'b1;
          if (cnt_q == addr_t'(BIAS_WORDS - 1)) begin
            cnt_clr = 1'b1;
            state_d = STREAM;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      STREAM: begin
        // Requests follow network backpressure; none once every operand has arrived.
        DDR3_Read_Req = Net_Input_Enable && !stream_done;
        DDR3_Address  = addr_t'(cur_q.d_read_base) + rd_off;
        if (DDR3_Input_Valid && !stream_done) begin
          Load_Operands = 1'b1;
          cnt_inc       = 1'b1;
        end
        if (Net_Done) begin
          state_d = NEXT;
        end else if (stream_done ||
                     (DDR3_Input_Valid && (cnt_q + addr_t'(1) == addr_t'(cur_q.operand_words)))) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (Net_Done) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        state_d = ({1'b0, layer_q} == num_q - 1'b1) ? DONE : NET_RST;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort_hit) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      layer_q <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && Begin_Calc) begin
        num_q   <= Num_Layers;
        layer_q <= '0;
      end
      if ((state_q == NEXT) && (state_d == NET_RST)) begin
        layer_q <= layer_q + 1'b1;
      end
      if (state_q == NET_RST) begin
        cur_q  <= table_desc;
        cnt_q  <= '0;
        wcnt_q <= '0;
      end else begin
        if (cnt_clr) begin
          cnt_q <= '0;
        end else if (cnt_inc) begin
          cnt_q <= cnt_q + 1'b1;
        end
        if (DDR3_WE) begin
          wcnt_q <= wcnt_q + 1'b1;
        end
      end
    end
  end

  assign DDR3_WE            = busy && Net_Result_Valid;
  assign DDR3_Write_Address = addr_t'(cur_q.d_write_base) + wcnt_q * addr_t'(WORD_BYTES);
  assign Network_Reset      = (state_q == NET_RST) || abort_hit;
  assign Aborted            = abort_hit;
  assign Proc_Done          = (state_q == DONE);
  assign Busy               = busy;
  assign Layer_Index        = layer_q;
  assign Layer_Type         = cur_q.layer_type;
  assign CNN_Stride         = cur_q.stride;
  assign CNN_Window_Dim     = cur_q.window_dim;
  assign CNN_Input_Dim      = DIM_WIDTH'(cur_q.input_dim);

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - randomized bench for layer_sequencer against a beat-trace model
module tb_layer_sequencer;
  import layer_seq_pkg::*;

  localparam int WW = 9;
  localparam int BW = 9;
  localparam int WB = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        Cfg_WE;
  logic [4:0]  Cfg_Index;
  logic [DESC_WIDTH-1:0] Cfg_Descriptor;
  logic [5:0]  Num_Layers;
  logic        Begin_Calc, Abort, DDR3_Input_Valid;
  logic        DDR3_Read_Req, DDR3_WE;
  logic [31:0] DDR3_Address, DDR3_Write_Address;
  logic        Net_Input_Enable, Net_Done, Net_Result_Valid;
  logic        Network_Reset, Load_Weights, Load_Biases, Load_Operands;
  logic [1:0]  Layer_Type, CNN_Window_Dim;
  logic        CNN_Stride;
  logic [7:0]  CNN_Input_Dim;
  logic [4:0]  Layer_Index;
  logic        Busy, Proc_Done, Aborted;

  always #5 clock = ~clock;

  layer_sequencer dut (
    .clock(clock), .reset(reset), .Cfg_WE(Cfg_WE), .Cfg_Index(Cfg_Index),
    .Cfg_Descriptor(Cfg_Descriptor), .Num_Layers(Num_Layers), .Begin_Calc(Begin_Calc),
    .Abort(Abort), .DDR3_Input_Valid(DDR3_Input_Valid), .DDR3_Read_Req(DDR3_Read_Req),
    .DDR3_Address(DDR3_Address), .DDR3_WE(DDR3_WE), .DDR3_Write_Address(DDR3_Write_Address),
    .Net_Input_Enable(Net_Input_Enable), .Net_Done(Net_Done), .Net_Result_Valid(Net_Result_Valid),
    .Network_Reset(Network_Reset), .Load_Weights(Load_Weights), .Load_Biases(Load_Biases),
    .Load_Operands(Load_Operands), .Layer_Type(Layer_Type), .CNN_Stride(CNN_Stride),
    .CNN_Window_Dim(CNN_Window_Dim), .CNN_Input_Dim(CNN_Input_Dim), .Layer_Index(Layer_Index),
    .Busy(Busy), .Proc_Done(Proc_Done), .Aborted(Aborted)
  );

  int checks = 0;
  int failures = 0;
  layer_desc_t descs [32];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic layer_desc_t mk_desc(input layer_type_e t, input int ops);
    layer_desc_t d;
    d.layer_type    = t;
    d.stride        = 1'($urandom_range(0, 1));
    d.window_dim    = 2'($urandom_range(0, 3));
    d.input_dim     = 8'($urandom_range(0, 255));
    d.w_base        = $urandom & 32'hFFFF_FFFC;
    d.b_base        = $urandom & 32'hFFFF_FFFC;
    d.d_read_base   = $urandom & 32'hFFFF_FFFC;
    d.d_write_base  = $urandom & 32'hFFFF_FFFC;
    d.operand_words = 32'(ops);
    return d;
  endfunction

  function automatic int op_target(input layer_desc_t d, input int early_k);
    if (early_k >= 0 && early_k < int'(d.operand_words)) return early_k;
    return int'(d.operand_words);
  endfunction

  task automatic program_table(input int n);
    for (int i = 0; i < n; i++) begin
      Cfg_WE = 1'b1;
      Cfg_Index = 5'(i);
      Cfg_Descriptor = descs[i];
      @(posedge clock); #1;
    end
    Cfg_WE = 1'b0;
  endtask

  task automatic run(input int id, input int n, input int vpct, input int epct, input int early_k,
                     input int abort_layer, input int abort_b, input bit cfg_busy);
    int exp_k[$], obs_k[$];
    logic [31:0] exp_a[$], obs_a[$];
    int layer, wb_seen, ops_seen, wr_k, wbt, opt, nb, pd_cyc;
    int nrst_n, pd_n, ab_n, rreq_n, mism;
    int first_bad, rr_bad, wr_bad, cfg_bad, busy_bad, ab_bad;
    bit active, done_sent, first_pending, finished, post_abort, abort_sent, cfg_sent;
    layer_desc_t cd;
    logic [31:0] ea;
    layer = -1; wb_seen = 0; ops_seen = 0; wr_k = 0; wbt = 0; opt = 0; pd_cyc = -1;
    nrst_n = 0; pd_n = 0; ab_n = 0; rreq_n = 0; mism = 0;
    first_bad = 0; rr_bad = 0; wr_bad = 0; cfg_bad = 0; busy_bad = 0; ab_bad = 0;
    active = 0; done_sent = 0; first_pending = 0; finished = 0;
    post_abort = 0; abort_sent = 0; cfg_sent = 0;

    // Expected load-beat trace: (kind, address) in order, 0=weight 1=bias 2=operand.
    for (int l = 0; l < n; l++) begin
      cd = descs[l];
      if (cd.layer_type != POOL) begin
        for (int i = 0; i < WW; i++) begin exp_k.push_back(0); exp_a.push_back(cd.w_base + 32'(WB * i)); end
        nb = (l == abort_layer) ? abort_b : BW;
        for (int i = 0; i < nb; i++) begin exp_k.push_back(1); exp_a.push_back(cd.b_base + 32'(WB * i)); end
      end
      if (l == abort_layer) break;
      for (int i = 0; i < op_target(cd, early_k); i++) begin
        exp_k.push_back(2); exp_a.push_back(cd.d_read_base + 32'(WB * i));
      end
    end

    Begin_Calc = 1'b1;
    Num_Layers = 6'(n);
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge clock);
      if (layer >= 0) begin
        cd  = descs[layer];
        wbt = (cd.layer_type == POOL) ? 0 : WW + BW;
        opt = op_target(cd, early_k);
      end
      if (DDR3_Read_Req) rreq_n++;
      if (post_abort) begin
        if (Busy) busy_bad++;
        if (Proc_Done) pd_n++;
        finished = 1;
      end else begin
        if (first_pending) begin
          first_pending = 0;
          if (cd.layer_type == POOL) begin
            if (DDR3_Address !== cd.d_read_base ||
                DDR3_Read_Req !== (Net_Input_Enable && cd.operand_words != 0)) first_bad++;
          end else if (DDR3_Address !== cd.w_base || DDR3_Read_Req !== 1'b1) first_bad++;
        end
        if (active && !done_sent && wb_seen == wbt && ops_seen < opt &&
            DDR3_Read_Req !== Net_Input_Enable) rr_bad++;
        if (Load_Weights) begin obs_k.push_back(0); obs_a.push_back(DDR3_Address); end
        if (Load_Biases) begin obs_k.push_back(1); obs_a.push_back(DDR3_Address); end
        if (Load_Operands) begin obs_k.push_back(2); obs_a.push_back(DDR3_Address); end
        if (Load_Weights || Load_Biases || Load_Operands) begin
          if (layer < 0 || int'(Layer_Index) != layer ||
              {Layer_Type, CNN_Stride, CNN_Window_Dim, CNN_Input_Dim} !==
              {cd.layer_type, cd.stride, cd.window_dim, cd.input_dim}) cfg_bad++;
        end
        if (Load_Weights || Load_Biases) wb_seen++;
        if (Load_Operands) ops_seen++;
        if (Net_Result_Valid) begin
          ea = cd.d_write_base + 32'(WB * wr_k);
          if (DDR3_WE !== 1'b1 || DDR3_Write_Address !== ea) wr_bad++;
          wr_k++;
        end else if (DDR3_WE !== 1'b0) wr_bad++;
        if (Aborted) begin
          ab_n++;
          if (!Network_Reset || Proc_Done) ab_bad++;
          post_abort = 1;
        end else if (Network_Reset) begin
          nrst_n++; layer++; active = 1; wb_seen = 0; ops_seen = 0;
          done_sent = 0; wr_k = 0; first_pending = 1;
          cd  = descs[layer];
          wbt = (cd.layer_type == POOL) ? 0 : WW + BW;
          opt = op_target(cd, early_k);
        end
        if (Proc_Done) begin
          pd_n++; pd_cyc = cyc;
          if (Busy) busy_bad++;
          finished = 1;
        end
      end
      if (!finished) begin
        @(posedge clock); #1;
        Begin_Calc = 1'b0; Cfg_WE = 1'b0; Net_Done = 1'b0; Abort = 1'b0;
        DDR3_Input_Valid = $urandom_range(0, 99) < vpct;
        Net_Input_Enable = $urandom_range(0, 99) < epct;
        Net_Result_Valid = active && !done_sent && ($urandom_range(0, 99) < 30);
        if (active && !done_sent && wb_seen == wbt && ops_seen >= opt &&
            (early_k >= 0 || $urandom_range(0, 2) == 0)) begin
          Net_Done = 1'b1; DDR3_Input_Valid = 1'b0; done_sent = 1;
        end
        if (layer == abort_layer && !abort_sent && wb_seen == WW + abort_b) begin
          Abort = 1'b1; DDR3_Input_Valid = 1'b0; Net_Result_Valid = 1'b0; abort_sent = 1;
        end
        if (cfg_busy && !cfg_sent && layer == 0 && wb_seen == 3) begin
          Cfg_WE = 1'b1; Cfg_Index = '0; Cfg_Descriptor = mk_desc(FC, 7); cfg_sent = 1;
        end
      end
    end
    @(posedge clock); #1;
    Begin_Calc = 1'b0; Cfg_WE = 1'b0; Net_Done = 1'b0; Abort = 1'b0;
    DDR3_Input_Valid = 1'b0; Net_Input_Enable = 1'b0; Net_Result_Valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    for (int i = 0; i < obs_k.size() && i < exp_k.size(); i++)
      if (obs_k[i] != exp_k[i] || obs_a[i] !== exp_a[i]) mism++;
    check($sformatf("r%0d_finished", id), int'(finished), 1);
    check($sformatf("r%0d_trace_len", id), obs_k.size(), exp_k.size());
    check($sformatf("r%0d_trace_mismatch", id), mism, 0);
    check($sformatf("r%0d_net_resets", id), nrst_n, (abort_layer >= 0) ? abort_layer + 1 : n);
    check($sformatf("r%0d_proc_done", id), pd_n, (abort_layer >= 0) ? 0 : 1);
    check($sformatf("r%0d_aborted", id), ab_n, (abort_layer >= 0) ? 1 : 0);
    check($sformatf("r%0d_first_addr", id), first_bad, 0);
    check($sformatf("r%0d_read_req_follow", id), rr_bad, 0);
    check($sformatf("r%0d_write_back", id), wr_bad, 0);
    check($sformatf("r%0d_layer_cfg", id), cfg_bad, 0);
    check($sformatf("r%0d_busy_at_end", id), busy_bad + ab_bad, 0);
    if (n == 0) begin
      check($sformatf("r%0d_no_read_req", id), rreq_n, 0);
      check($sformatf("r%0d_done_latency", id), pd_cyc, 1);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; Cfg_WE = 1'b0; Cfg_Index = '0; Cfg_Descriptor = '0; Num_Layers = '0;
    Begin_Calc = 1'b0; Abort = 1'b0; DDR3_Input_Valid = 1'b0; Net_Input_Enable = 1'b0;
    Net_Done = 1'b0; Net_Result_Valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", int'(Busy), 0);
    check("rst_pulses", int'({Proc_Done, Aborted, Network_Reset}), 0);
    check("rst_ddr", int'({DDR3_Read_Req, DDR3_WE, Load_Weights, Load_Biases, Load_Operands}), 0);
    check("rst_addr", int'(DDR3_Address | DDR3_Write_Address), 0);
    check("rst_cfg", int'({Layer_Type, CNN_Stride, CNN_Window_Dim, CNN_Input_Dim, Layer_Index}), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    descs[0] = mk_desc(CONV, 4); descs[0].d_write_base = 32'h100;
    descs[1] = mk_desc(FC, 4);
    program_table(2);
    run(1, 2, 100, 100, -1, -1, 0, 1'b0);

    descs[0] = mk_desc(CONV, 5); descs[1] = mk_desc(POOL, 6); descs[2] = mk_desc(FC, 3);
    program_table(3);
    run(2, 3, 70, 50, -1, -1, 0, 1'b0);

    descs[0] = mk_desc(FC, 6); descs[1] = mk_desc(POOL, 7);
    program_table(2);
    run(3, 2, 80, 80, 2, -1, 0, 1'b0);

    descs[0] = mk_desc(CONV, 3); descs[1] = mk_desc(CONV, 3);
    program_table(2);
    run(4, 2, 100, 100, -1, 1, 4, 1'b1);
    run(5, 2, 90, 70, -1, -1, 0, 1'b0);

    run(6, 0, 100, 100, -1, -1, 0, 1'b0);

    descs[0] = mk_desc(CONV, 0); descs[0].w_base = 32'hFFFF_FFF0; descs[0].b_base = 32'hFFFF_FFFC;
    descs[1] = mk_desc(POOL, 2); descs[1].d_read_base = 32'hFFFF_FFFC;
    program_table(2);
    run(7, 2, 60, 60, -1, -1, 0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 4);
      for (int l = 0; l < n; l++) begin
        case ($urandom_range(0, 2))
          0:       descs[l] = mk_desc(CONV, $urandom_range(0, 8));
          1:       descs[l] = mk_desc(POOL, $urandom_range(0, 8));
          default: descs[l] = mk_desc(FC, $urandom_range(0, 8));
        endcase
      end
      program_table(n);
      run(8 + r, n, $urandom_range(40, 100), $urandom_range(30, 100), -1, -1, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
